// File: rtl/serial_shift_driver.sv
// ---------------------------------------------------------------------------
// serial_shift_driver
//
// Shifts a parallel word out bit-serially to an external shift-register
// peripheral (7-segment digit chain, LED bank), then pulses a latch strobe.
// A frame is DATA_W shift-clock periods followed by one latch period of the
// same length. Each period is 2*CLK_DIV system clocks: CLK_DIV low, CLK_DIV high.
//
// Parameters
//   DATA_W    bits per frame (>=1)
//   CLK_DIV   system clocks per shift-clock half period (>=1)
//   LSB_FIRST 0: data_in[DATA_W-1] goes out first, 1: data_in[0] goes out first
//   INVERT    1: serial data is driven inverted (active-low segment drivers)
//   AUTO_REF  >0: resend the stored word AUTO_REF cycles after each done; 0: off
//
// Ports
//   clk_100mhz  in   system clock, rising edge
//   rst         in   synchronous reset, active-high
//   data_in     in   frame to send, sampled only when a load is accepted
//   load        in   send request, accepted only while busy is low
//   busy        out  frame in progress
//   done        out  one-cycle pulse in the first idle cycle after a frame
//   sclk        out  shift clock to the external register
//   sdo         out  serial data, stable across each sclk rising edge
//   spen        out  latch strobe, high for the first half of the latch period
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module serial_shift_driver #(
    parameter int DATA_W    = 64,
    parameter int CLK_DIV   = 4,
    parameter int LSB_FIRST = 0,
    parameter int INVERT    = 0,
    parameter int AUTO_REF  = 0
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              sdo,
    output logic              spen
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int REF_W = (AUTO_REF > 0) ? $clog2(AUTO_REF + 1) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [REF_W-1:0] REF_MAX  = REF_W'(AUTO_REF);
    localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);
    localparam logic             INV_BIT  = (INVERT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Bit that leaves the shift register next, in the configured order.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        logic b;
        if (LSB_FIRST != 0) begin
            b = w[0];
        end else begin
            b = w[DATA_W-1];
        end
        return b;
    endfunction

    // Shift register contents after the next bit has been taken.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        if (LSB_FIRST != 0) begin
            r = w >> 1'b1;
        end else begin
            r = w << 1'b1;
        end
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [DIV_W-1:0]  div_r,   div_s;     // cycles spent in the current half period
    logic              half_r,  half_s;    // 0: first half of a period, 1: second half
    logic [BIT_W-1:0]  bit_r,   bit_s;     // index of the bit currently on sdo
    logic [DATA_W-1:0] shreg_r, shreg_s;   // bits still to be sent
    logic [DATA_W-1:0] stored_r, stored_s; // last explicitly loaded word, for refresh
    logic [REF_W-1:0]  ref_r,   ref_s;     // idle cycles since done, 0 = refresh disarmed

    logic busy_r, busy_s;
    logic done_r, done_s;
    logic sclk_r, sclk_s;
    logic sdo_r,  sdo_s;
    logic spen_r, spen_s;

    logic              start_s;
    logic [DATA_W-1:0] start_word_s;
    logic              ref_hit_s;

    // The refresh counter is only armed by a completed frame, so a fresh
    // reset never sends the all-zero stored word on its own.
    assign ref_hit_s = (AUTO_REF > 0) && (ref_r == REF_MAX);

    // Next-state and next-output logic for the IDLE/SHIFT/LATCH sequencer.
    always_comb begin
        state_s      = state_r;
        div_s        = div_r;
        half_s       = half_r;
        bit_s        = bit_r;
        shreg_s      = shreg_r;
        stored_s     = stored_r;
        ref_s        = ref_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        sclk_s       = sclk_r;
        sdo_s        = sdo_r;
        spen_s       = spen_r;
        start_s      = 1'b0;
        start_word_s = data_in;

        case (state_r)
            IDLE: begin
                // An explicit load wins over a due refresh and restarts the count.
                if (load) begin
                    start_s      = 1'b1;
                    start_word_s = data_in;
                    stored_s     = data_in;
                    ref_s        = '0;
                end else if (ref_hit_s) begin
                    start_s      = 1'b1;
                    start_word_s = stored_r;
                    ref_s        = '0;
                end else if ((ref_r != '0) && (ref_r != REF_MAX)) begin
                    ref_s = ref_r + 1'b1;
                end else begin
                    ref_s = ref_r;
                end

                // The first bit is presented together with busy, sclk low.
                if (start_s) begin
                    state_s = SHIFT;
                    busy_s  = 1'b1;
                    div_s   = '0;
                    half_s  = 1'b0;
                    bit_s   = '0;
                    sclk_s  = 1'b0;
                    spen_s  = 1'b0;
                    sdo_s   = first_bit(start_word_s) ^ INV_BIT;
                    shreg_s = shift_out(start_word_s);
                end else begin
                    sclk_s = 1'b0;
                    spen_s = 1'b0;
                end
            end

            SHIFT: begin
                if (div_r == DIV_LAST) begin
                    div_s = '0;
                    if (half_r == 1'b0) begin
                        half_s = 1'b1;
                        sclk_s = 1'b1;
                    end else if (bit_r == BIT_LAST) begin
                        // Last bit clocked: sdo keeps it through the latch period.
                        state_s = LATCH;
                        half_s  = 1'b0;
                        sclk_s  = 1'b0;
                        spen_s  = 1'b1;
                    end else begin
                        // New bit only while sclk is low, so it is settled at the rise.
                        half_s  = 1'b0;
                        sclk_s  = 1'b0;
                        bit_s   = bit_r + 1'b1;
                        sdo_s   = first_bit(shreg_r) ^ INV_BIT;
                        shreg_s = shift_out(shreg_r);
                    end
                end else begin
                    div_s = div_r + 1'b1;
                end
            end

            LATCH: begin
                if (div_r == DIV_LAST) begin
                    div_s = '0;
                    if (half_r == 1'b0) begin
                        half_s = 1'b1;
                        spen_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                        half_s  = 1'b0;
                        bit_s   = '0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        // Arm the refresh; the done cycle counts as the first idle cycle.
                        ref_s   = (AUTO_REF > 0) ? REF_ONE : '0;
                    end
                end else begin
                    div_s = div_r + 1'b1;
                end
            end

            default: begin
                state_s = IDLE;
                div_s   = '0;
                half_s  = 1'b0;
                bit_s   = '0;
                ref_s   = '0;
                busy_s  = 1'b0;
                sclk_s  = 1'b0;
                sdo_s   = 1'b0;
                spen_s  = 1'b0;
            end
        endcase
    end

    // Sequencer, counter and output registers; reset aborts any frame silently.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_r  <= IDLE;
            div_r    <= '0;
            half_r   <= 1'b0;
            bit_r    <= '0;
            shreg_r  <= '0;
            stored_r <= '0;
            ref_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sclk_r   <= 1'b0;
            sdo_r    <= 1'b0;
            spen_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            div_r    <= div_s;
            half_r   <= half_s;
            bit_r    <= bit_s;
            shreg_r  <= shreg_s;
            stored_r <= stored_s;
            ref_r    <= ref_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            sclk_r   <= sclk_s;
            sdo_r    <= sdo_s;
            spen_r   <= spen_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sclk = sclk_r;
    assign sdo  = sdo_r;
    assign spen = spen_r;

endmodule

// File: tb/tb_serial_shift_driver.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_driver
//
// Three instances: u0 (8 bits, div 2, MSB first), u1 (8 bits, div 2, LSB
// first, inverted, refresh 20) and u2 (1 bit, div 1). Expected pin values for
// every cycle of a frame come from model(), which derives them from the frame
// timing rules: cycle t after the load edge, bit period 2*CLK_DIV, latch
// period after DATA_W bits, done one cycle after busy ends.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_shift_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst0, load0, busy0, done0, sclk0, sdo0, spen0;
    logic [7:0] data0;
    logic       rst1, load1, busy1, done1, sclk1, sdo1, spen1;
    logic [7:0] data1;
    logic       rst2, load2, busy2, done2, sclk2, sdo2, spen2;
    logic [0:0] data2;

    serial_shift_driver #(.DATA_W(8), .CLK_DIV(2), .LSB_FIRST(0), .INVERT(0), .AUTO_REF(0)) u0 (
        .clk_100mhz(clk), .rst(rst0), .data_in(data0), .load(load0),
        .busy(busy0), .done(done0), .sclk(sclk0), .sdo(sdo0), .spen(spen0));

    serial_shift_driver #(.DATA_W(8), .CLK_DIV(2), .LSB_FIRST(1), .INVERT(1), .AUTO_REF(20)) u1 (
        .clk_100mhz(clk), .rst(rst1), .data_in(data1), .load(load1),
        .busy(busy1), .done(done1), .sclk(sclk1), .sdo(sdo1), .spen(spen1));

    serial_shift_driver #(.DATA_W(1), .CLK_DIV(1), .LSB_FIRST(0), .INVERT(0), .AUTO_REF(0)) u2 (
        .clk_100mhz(clk), .rst(rst2), .data_in(data2), .load(load2),
        .busy(busy2), .done(done2), .sclk(sclk2), .sdo(sdo2), .spen(spen2));

    typedef struct packed {
        logic busy;
        logic done;
        logic sclk;
        logic sdo;
        logic spen;
    } exp_t;

    // Expected pins in cycle t (t=1 is the first cycle after the load edge).
    function automatic exp_t model(input int t, input logic [7:0] w, input int dw,
                                   input int cd, input bit lsb, input bit inv);
        exp_t m;
        int per;
        int shift_len;
        int frame_len;
        int bi;
        logic b;
        m         = '0;
        per       = 2 * cd;
        shift_len = per * dw;
        frame_len = per * (dw + 1);
        if (t >= 1 && t <= frame_len) begin
            m.busy = 1'b1;
            if (t <= shift_len) begin
                bi     = (t - 1) / per;
                m.sclk = (((t - 1) % per) >= cd);
            end else begin
                bi     = dw - 1;
                m.spen = ((t - shift_len) <= cd);
            end
            b     = lsb ? w[bi] : w[dw - 1 - bi];
            m.sdo = b ^ inv;
        end
        m.done = (t == frame_len + 1);
        return m;
    endfunction

    task automatic test_reset;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        load0 = 1'b0; load1 = 1'b0; load2 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; data2 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy0, done0, sclk0, sdo0, spen0} !== 5'b0) begin
            bad++; $display("FAIL reset_u0 got=%b exp=00000", {busy0, done0, sclk0, sdo0, spen0});
        end
        total++;
        if ({busy1, done1, sclk1, sdo1, spen1} !== 5'b0) begin
            bad++; $display("FAIL reset_u1 got=%b exp=00000", {busy1, done1, sclk1, sdo1, spen1});
        end
        total++;
        if ({busy2, done2, sclk2, sdo2, spen2} !== 5'b0) begin
            bad++; $display("FAIL reset_u2 got=%b exp=00000", {busy2, done2, sclk2, sdo2, spen2});
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Frame A5: per-cycle pins, bit order seen at sclk rises, data_in noise ignored.
    task automatic test_single_frame;
        exp_t e;
        logic [7:0] got;
        logic prev;
        got = 8'h00; prev = 1'b0;
        data0 = 8'hA5; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            e = model(t, 8'hA5, 8, 2, 1'b0, 1'b0);
            total++;
            if ({busy0, done0, sclk0, spen0} !== {e.busy, e.done, e.sclk, e.spen}) begin
                bad++; $display("FAIL single_ctl t=%0d got=%b exp=%b", t, {busy0, done0, sclk0, spen0}, {e.busy, e.done, e.sclk, e.spen});
            end
            if (e.busy) begin
                total++;
                if (sdo0 !== e.sdo) begin
                    bad++; $display("FAIL single_sdo t=%0d got=%b exp=%b", t, sdo0, e.sdo);
                end
            end
            if (!prev && sclk0) got = {got[6:0], sdo0};
            prev  = sclk0;
            data0 = 8'($urandom);
            @(negedge clk);
        end
        total++;
        if (got !== 8'hA5) begin
            bad++; $display("FAIL single_bits got=%h exp=a5", got);
        end
    endtask

    // Load during a frame is dropped; load on the done cycle starts the next frame.
    task automatic test_ignore_load;
        exp_t e;
        logic [7:0] w2;
        w2 = 8'($urandom);
        data0 = 8'hA5; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        for (int t = 1; t <= 37; t++) begin
            e = model(t, 8'hA5, 8, 2, 1'b0, 1'b0);
            total++;
            if ({busy0, done0, sclk0, spen0} !== {e.busy, e.done, e.sclk, e.spen}) begin
                bad++; $display("FAIL ignore_ctl t=%0d got=%b exp=%b", t, {busy0, done0, sclk0, spen0}, {e.busy, e.done, e.sclk, e.spen});
            end
            if (e.busy) begin
                total++;
                if (sdo0 !== e.sdo) begin
                    bad++; $display("FAIL ignore_sdo t=%0d got=%b exp=%b", t, sdo0, e.sdo);
                end
            end
            if (t == 10) begin data0 = 8'hFF; load0 = 1'b1; end
            else if (t == 37) begin data0 = w2; load0 = 1'b1; end
            else load0 = 1'b0;
            @(negedge clk);
        end
        load0 = 1'b0;
        for (int t = 1; t <= 38; t++) begin
            e = model(t, w2, 8, 2, 1'b0, 1'b0);
            total++;
            if ({busy0, done0, sclk0, spen0} !== {e.busy, e.done, e.sclk, e.spen}) begin
                bad++; $display("FAIL b2b_ctl t=%0d got=%b exp=%b", t, {busy0, done0, sclk0, spen0}, {e.busy, e.done, e.sclk, e.spen});
            end
            if (e.busy) begin
                total++;
                if (sdo0 !== e.sdo) begin
                    bad++; $display("FAIL b2b_sdo t=%0d got=%b exp=%b", t, sdo0, e.sdo);
                end
            end
            @(negedge clk);
        end
    endtask

    // Random words, random idle gaps (0 = back-to-back), random loads while busy.
    task automatic test_random;
        exp_t e;
        logic [7:0] w;
        logic [7:0] nxt;
        int gap;
        w = 8'($urandom); nxt = w;
        data0 = w; load0 = 1'b1;
        for (int f = 0; f < 6; f++) begin
            @(negedge clk);
            load0 = 1'b0;
            gap = $urandom_range(0, 3);
            for (int t = 1; t <= 37 + gap; t++) begin
                e = model(t, w, 8, 2, 1'b0, 1'b0);
                total++;
                if ({busy0, done0, sclk0, spen0} !== {e.busy, e.done, e.sclk, e.spen}) begin
                    bad++; $display("FAIL rand_ctl f=%0d t=%0d got=%b exp=%b", f, t, {busy0, done0, sclk0, spen0}, {e.busy, e.done, e.sclk, e.spen});
                end
                if (e.busy) begin
                    total++;
                    if (sdo0 !== e.sdo) begin
                        bad++; $display("FAIL rand_sdo f=%0d t=%0d got=%b exp=%b", f, t, sdo0, e.sdo);
                    end
                end
                if (t < 37) begin
                    load0 = 1'($urandom_range(0, 1));
                    data0 = 8'($urandom);
                end else if (t == 37 + gap) begin
                    nxt   = 8'($urandom);
                    data0 = nxt;
                    load0 = (f < 5);
                end else begin
                    load0 = 1'b0;
                end
                if (t < 37 + gap) @(negedge clk);
            end
            w = nxt;
        end
        @(negedge clk);
        load0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Reset mid-shift: outputs drop next cycle, no done, then a clean fresh frame.
    task automatic test_reset_mid_frame;
        exp_t e;
        logic [7:0] w;
        w = 8'($urandom);
        data0 = w; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        for (int t = 1; t <= 15; t++) begin
            e = model(t, w, 8, 2, 1'b0, 1'b0);
            total++;
            if ({busy0, sclk0, spen0} !== {e.busy, e.sclk, e.spen}) begin
                bad++; $display("FAIL pre_rst t=%0d got=%b exp=%b", t, {busy0, sclk0, spen0}, {e.busy, e.sclk, e.spen});
            end
            if (t == 15) rst0 = 1'b1;
            @(negedge clk);
        end
        total++;
        if ({busy0, done0, sclk0, sdo0, spen0} !== 5'b0) begin
            bad++; $display("FAIL mid_rst got=%b exp=00000", {busy0, done0, sclk0, sdo0, spen0});
        end
        rst0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if ({busy0, done0} !== 2'b00) begin
                bad++; $display("FAIL post_rst_idle i=%0d got=%b exp=00", i, {busy0, done0});
            end
        end
        w = 8'($urandom);
        data0 = w; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        for (int t = 1; t <= 38; t++) begin
            e = model(t, w, 8, 2, 1'b0, 1'b0);
            total++;
            if ({busy0, done0, sclk0, spen0} !== {e.busy, e.done, e.sclk, e.spen}) begin
                bad++; $display("FAIL fresh_ctl t=%0d got=%b exp=%b", t, {busy0, done0, sclk0, spen0}, {e.busy, e.done, e.sclk, e.spen});
            end
            if (e.busy) begin
                total++;
                if (sdo0 !== e.sdo) begin
                    bad++; $display("FAIL fresh_sdo t=%0d got=%b exp=%b", t, sdo0, e.sdo);
                end
            end
            @(negedge clk);
        end
    endtask

    // LSB-first, inverted: 8'h01 must appear as 0,1,1,1,1,1,1,1 at sclk rises.
    task automatic test_lsb_invert;
        exp_t e;
        logic [7:0] got;
        logic prev;
        got = 8'h00; prev = 1'b0;
        data1 = 8'h01; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        for (int t = 1; t <= 38; t++) begin
            e = model(t, 8'h01, 8, 2, 1'b1, 1'b1);
            total++;
            if ({busy1, done1, sclk1, spen1} !== {e.busy, e.done, e.sclk, e.spen}) begin
                bad++; $display("FAIL lsbinv_ctl t=%0d got=%b exp=%b", t, {busy1, done1, sclk1, spen1}, {e.busy, e.done, e.sclk, e.spen});
            end
            if (e.busy) begin
                total++;
                if (sdo1 !== e.sdo) begin
                    bad++; $display("FAIL lsbinv_sdo t=%0d got=%b exp=%b", t, sdo1, e.sdo);
                end
            end
            if (!prev && sclk1) got = {sdo1, got[7:1]};
            prev = sclk1;
            @(negedge clk);
        end
        total++;
        if (got !== 8'hFE) begin
            bad++; $display("FAIL lsbinv_bits got=%h exp=fe", got);
        end
        // Reset disarms the pending refresh before the next scenario.
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (busy1 !== 1'b0) begin
                bad++; $display("FAIL no_refresh_after_rst i=%0d got=%b exp=0", i, busy1);
            end
        end
    endtask

    // Refresh every 20 idle cycles with the stored word; explicit load overrides.
    task automatic test_auto_refresh;
        exp_t e;
        int tt;
        data1 = 8'h3C; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        data1 = 8'($urandom);
        for (int t = 1; t <= 98; t++) begin
            tt = ((t - 1) % 56) + 1;
            e = model(tt, 8'h3C, 8, 2, 1'b1, 1'b1);
            total++;
            if ({busy1, done1, sclk1, spen1} !== {e.busy, e.done, e.sclk, e.spen}) begin
                bad++; $display("FAIL ref3c_ctl t=%0d got=%b exp=%b", t, {busy1, done1, sclk1, spen1}, {e.busy, e.done, e.sclk, e.spen});
            end
            if (e.busy) begin
                total++;
                if (sdo1 !== e.sdo) begin
                    bad++; $display("FAIL ref3c_sdo t=%0d got=%b exp=%b", t, sdo1, e.sdo);
                end
            end
            if (t == 98) begin data1 = 8'hC3; load1 = 1'b1; end
            @(negedge clk);
        end
        load1 = 1'b0;
        data1 = 8'($urandom);
        for (int t = 1; t <= 122; t++) begin
            tt = ((t - 1) % 56) + 1;
            e = model(tt, 8'hC3, 8, 2, 1'b1, 1'b1);
            total++;
            if ({busy1, done1, sclk1, spen1} !== {e.busy, e.done, e.sclk, e.spen}) begin
                bad++; $display("FAIL refc3_ctl t=%0d got=%b exp=%b", t, {busy1, done1, sclk1, spen1}, {e.busy, e.done, e.sclk, e.spen});
            end
            if (e.busy) begin
                total++;
                if (sdo1 !== e.sdo) begin
                    bad++; $display("FAIL refc3_sdo t=%0d got=%b exp=%b", t, sdo1, e.sdo);
                end
            end
            @(negedge clk);
        end
    endtask

    // One-bit frame, divider 1: 4 busy cycles, sclk 0,1,0,0, one-cycle spen.
    task automatic test_min_size;
        exp_t e;
        logic w;
        logic [3:0] sclk_seq;
        int busy_cnt;
        for (int f = 0; f < 3; f++) begin
            w = 1'($urandom_range(0, 1));
            sclk_seq = 4'b0000; busy_cnt = 0;
            data2 = w; load2 = 1'b1;
            @(negedge clk);
            load2 = 1'b0;
            for (int t = 1; t <= 6; t++) begin
                e = model(t, {7'b0000000, w}, 1, 1, 1'b0, 1'b0);
                total++;
                if ({busy2, done2, sclk2, spen2} !== {e.busy, e.done, e.sclk, e.spen}) begin
                    bad++; $display("FAIL min_ctl f=%0d t=%0d got=%b exp=%b", f, t, {busy2, done2, sclk2, spen2}, {e.busy, e.done, e.sclk, e.spen});
                end
                if (e.busy) begin
                    total++;
                    if (sdo2 !== e.sdo) begin
                        bad++; $display("FAIL min_sdo f=%0d t=%0d got=%b exp=%b", f, t, sdo2, e.sdo);
                    end
                end
                if (t <= 4) sclk_seq = {sclk_seq[2:0], sclk2};
                if (busy2 === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            total++;
            if (sclk_seq !== 4'b0100 || busy_cnt != 4) begin
                bad++; $display("FAIL min_shape f=%0d sclk=%b busy_cycles=%0d exp sclk=0100 busy_cycles=4", f, sclk_seq, busy_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignore_load();
        test_random();
        test_reset_mid_frame();
        test_lsb_invert();
        test_auto_refresh();
        test_min_size();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
